// File: rtl/sd_sector_reader.sv
// Fetches one SD sector in SPI mode: issues CMD17, parses R1 and data token, stores the block.
// Optional macro SD_CRC16_EN enables CRC16-CCITT checking of the received data block.
`timescale 1ns/1ps
module sd_sector_reader #(
  parameter int BLOCK_BYTES   = 512,
  parameter int R1_TIMEOUT    = 8,
  parameter int TOKEN_TIMEOUT = 4096,
  localparam int IDX_W = $clog2(BLOCK_BYTES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      sector_addr,
  output logic             busy,
  output logic             done,
  output logic [2:0]       error,
  output logic [7:0]       r1,
  output logic [47:0]      sd_cmd,
  output logic             sd_start,
  input  logic             sd_byte_valid,
  input  logic [7:0]       sd_byte,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  localparam int TMAX  = (R1_TIMEOUT > TOKEN_TIMEOUT) ? R1_TIMEOUT : TOKEN_TIMEOUT;
  localparam int CNT_W = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT_R1, S_WAIT_TOKEN, S_DATA, S_CRC, S_FIN, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [2:0]       error_q, error_d;
  logic [2:0]       pend_q, pend_d;
  logic [7:0]       r1_q, r1_d;
  logic [47:0]      cmd_q, cmd_d;
  logic             sd_start_q, sd_start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             buf_we;
  logic [7:0]       mem [BLOCK_BYTES];
  logic [7:0]       rd_data_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

`ifdef SD_CRC16_EN
  logic [15:0] crc_calc_q, crc_calc_d;
  logic [15:0] crc_rx_q, crc_rx_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    pend_d     = pend_q;
    r1_d       = r1_q;
    cmd_d      = cmd_q;
    sd_start_d = 1'b0;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    buf_we     = 1'b0;
`ifdef SD_CRC16_EN
    crc_calc_d = crc_calc_q;
    crc_rx_d   = crc_rx_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d      = {8'h51, sector_addr, 8'hFF};
          done_d     = 1'b0;
          error_d    = 3'd0;
          busy_d     = 1'b1;
          sd_start_d = 1'b1;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        cnt_d   = '0;
        state_d = S_WAIT_R1;
      end
      S_WAIT_R1: begin
        if (sd_byte_valid) begin
          if (sd_byte[7]) begin
            cnt_d = sat_inc(cnt_q);
            if (cnt_d >= CNT_W'(R1_TIMEOUT)) begin
              pend_d  = 3'd1;
              state_d = S_ERR;
            end
          end else begin
            r1_d = sd_byte;
            if (sd_byte == 8'h00) begin
              cnt_d   = '0;
              state_d = S_WAIT_TOKEN;
            end else begin
              pend_d  = 3'd2;
              state_d = S_ERR;
            end
          end
        end
      end
      S_WAIT_TOKEN: begin
        if (sd_byte_valid) begin
          if (sd_byte == 8'hFE) begin
            idx_d   = '0;
`ifdef SD_CRC16_EN
            crc_calc_d = 16'h0000;
`endif
            state_d = S_DATA;
          end else if (sd_byte[7:4] == 4'h0) begin
            pend_d  = 3'd4;
            state_d = S_ERR;
          end else begin
            cnt_d = sat_inc(cnt_q);
            if (cnt_d >= CNT_W'(TOKEN_TIMEOUT)) begin
              pend_d  = 3'd3;
              state_d = S_ERR;
            end
          end
        end
      end
      S_DATA: begin
        if (sd_byte_valid) begin
          buf_we = 1'b1;
`ifdef SD_CRC16_EN
          crc_calc_d = crc16_byte(crc_calc_q, sd_byte);
`endif
          if (idx_q == IDX_W'(BLOCK_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = S_CRC;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_CRC: begin
        if (sd_byte_valid) begin
`ifdef SD_CRC16_EN
          crc_rx_d = {crc_rx_q[7:0], sd_byte};
`endif
          if (cnt_q[0]) state_d = S_FIN;
          else          cnt_d   = CNT_W'(1);
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
`ifdef SD_CRC16_EN
        error_d = (crc_calc_q != crc_rx_q) ? 3'd5 : 3'd0;
`else
        error_d = 3'd0;
`endif
        state_d = S_IDLE;
      end
      S_ERR: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        error_d = pend_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 3'd0;
      pend_q     <= 3'd0;
      r1_q       <= 8'hFF;
      cmd_q      <= 48'h0;
      sd_start_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      pend_q     <= pend_d;
      r1_q       <= r1_d;
      cmd_q      <= cmd_d;
      sd_start_q <= sd_start_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
    end
  end

`ifdef SD_CRC16_EN
  always_ff @(posedge clock) begin
    crc_calc_q <= crc_calc_d;
    crc_rx_q   <= crc_rx_d;
  end
`endif

  // Buffer survives reset; read returns pre-write contents on a same-index collision
  always_ff @(posedge clock) begin
    if (buf_we) mem[idx_q] <= sd_byte;
    rd_data_q <= mem[rd_addr];
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign r1       = r1_q;
  assign sd_cmd   = cmd_q;
  assign sd_start = sd_start_q;
  assign rd_data  = rd_data_q;

endmodule
